// File: rtl/fir_stream_pkg.sv
// fir_stream_pkg: shared constants and arithmetic helpers for the streaming FIR.
// Latency: n/a (combinational functions only).
// Backpressure: n/a.
// Contents: mode constants, acc_width() sizing helper, round_sat() scaling helper.
package fir_stream_pkg;

  localparam logic MODE_FIR    = 1'b0;
  localparam logic MODE_BYPASS = 1'b1;

  // round_sat works on a fixed 64-bit signed container; callers sign-extend
  // their accumulator into it and keep the low OUT_W bits of the result.
  localparam int RS_W = 64;

  typedef struct packed {
    logic signed [RS_W-1:0] val;
    logic                   sat;
  } rs_t;

  // Width that holds a TAPS-term sum of data_w x coef_w products without overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Round half-up at the binary point, arithmetic shift down, clip to out_w bits.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc,
                                    input int shift, input int out_w);
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    rs_t res;
    r = acc;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    r  = r >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    res.val = r;
    res.sat = 1'b0;
    if (r > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_stream_mac.sv
// fir_stream_mac: TAPS-wide signed multiply and sum of delay line x coefficients.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the parent decides when the sum is captured.
// Ports: x_flat (tap k at bits [k*DATA_W +: DATA_W]), coef_flat (tap k at
// [k*CW +: CW]), acc (full-precision signed sum).
module fir_stream_mac
  import fir_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CW     = 9,
  parameter int TAPS   = 8,
  localparam int ACC_W = acc_width(DATA_W, CW, TAPS)
) (
  input  logic [TAPS*DATA_W-1:0] x_flat,
  input  logic [TAPS*CW-1:0]     coef_flat,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PROD_W = DATA_W + CW;

  // Operands are sign-extended to the product width first so the truncated
  // PROD_W-bit product is the exact signed result. The linear sum is left for
  // synthesis to rebalance into a tree.
  always_comb begin
    logic signed [PROD_W-1:0] xs;
    logic signed [PROD_W-1:0] cs;
    logic signed [PROD_W-1:0] prod;
    xs   = '0;
    cs   = '0;
    prod = '0;
    acc  = '0;
    for (int k = 0; k < TAPS; k++) begin
      xs   = {{CW{x_flat[k*DATA_W+DATA_W-1]}}, x_flat[k*DATA_W +: DATA_W]};
      cs   = {{DATA_W{coef_flat[k*CW+CW-1]}}, coef_flat[k*CW +: CW]};
      prod = xs * cs;
      acc  = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/fir_stream.sv
// fir_stream: streaming direct-form FIR with loadable taps, bypass and round/saturate.
// Latency: sample accepted at edge N is presented with out_valid at edge N+1.
// Backpressure: in_ready = !out_valid | out_ready (and !clear); a stall freezes
// the delay line, stage-1 valid and the output register.
// Ports: clk/rst_n, clear (flush), bypass, in_valid/in_ready/in_data,
// out_valid/out_ready/out_data/out_sat, coef_we/coef_addr/coef_wdata.
module fir_stream
  import fir_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     bypass,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata
);

  // Coefficient storage carries one extra bit so the reset identity tap
  // 1<<SHIFT stays representable when SHIFT = COEF_W-1 (e.g. +128 for Q1.7).
  // Written values are sign-extended, so their arithmetic is unchanged.
  localparam int CW    = COEF_W + 1;
  localparam int ACC_W = acc_width(DATA_W, CW, TAPS);
  localparam logic [CW-1:0]      COEF_ONE = CW'(64'd1 << SHIFT);
  localparam logic [TAPS*CW-1:0] COEF_RST = {{((TAPS-1)*CW){1'b0}}, COEF_ONE};

  logic [TAPS*DATA_W-1:0] x_q, x_d;
  logic [TAPS*CW-1:0]     coef_q, coef_d;
  logic                   v1_q, v1_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_W-1:0]       out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;

  logic                    adv;
  logic                    accept;
  logic signed [ACC_W-1:0] mac_acc;
  logic signed [ACC_W-1:0] acc_sel;
  logic signed [RS_W-1:0]  acc_ext;
  rs_t                     rs;
  logic                    rs_hi_unused;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && !clear;
  assign accept   = in_valid && in_ready;

  fir_stream_mac #(
    .DATA_W (DATA_W),
    .CW     (CW),
    .TAPS   (TAPS)
  ) u_mac (
    .x_flat    (x_q),
    .coef_flat (coef_q),
    .acc       (mac_acc)
  );

  // Bypass feeds the newest sample, pre-scaled by 1<<SHIFT, through the same
  // round/saturate path so it leaves unchanged with identical latency.
  always_comb begin
    acc_sel = mac_acc;
    if (bypass == MODE_BYPASS) begin
      acc_sel = {{(ACC_W-DATA_W){x_q[DATA_W-1]}}, x_q[DATA_W-1:0]} <<< SHIFT;
    end
    acc_ext = {{(RS_W-ACC_W){acc_sel[ACC_W-1]}}, acc_sel};
    rs      = round_sat(acc_ext, SHIFT, OUT_W);
  end

  // Saturation already bounds the value to OUT_W bits; the upper bits are redundant.
  assign rs_hi_unused = ^rs.val[RS_W-1:OUT_W];

  always_comb begin
    x_d         = x_q;
    coef_d      = coef_q;
    v1_d        = v1_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (clear) begin
      x_d         = '0;
      v1_d        = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (accept) x_d = {x_q[(TAPS-1)*DATA_W-1:0], in_data};
      if (adv) begin
        v1_d        = accept;
        out_valid_d = v1_q;
        if (v1_q) begin
          out_data_d = rs.val[OUT_W-1:0];
          out_sat_d  = rs.sat;
        end
      end
    end

    if (coef_we && (int'(coef_addr) < TAPS)) begin
      coef_d[int'(coef_addr)*CW +: CW] = {coef_wdata[COEF_W-1], coef_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      coef_q      <= COEF_RST;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      coef_q      <= coef_d;
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_stream.sv
// tb_fir_stream: table vectors, directed corner sequences and randomized
// streaming against a queue-based reference model of the FIR.
module tb_fir_stream;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              bypass = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [7:0] out_data;
  logic              out_sat;
  logic              coef_we = 1'b0;
  logic [2:0]        coef_addr = '0;
  logic signed [7:0] coef_wdata = '0;

  int vectors = 0;
  int miscompares = 0;

  fir_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bypass     (bypass),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int hist[$];     // accepted samples, newest first
  int coef_m[8];
  int expq[$];
  bit satq[$];

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model_eval(output int v, output bit s);
    int sum;
    sum = 0;
    if (bypass) sum = hist[0] * 128;
    else for (int k = 0; k < hist.size(); k++) sum += hist[k] * coef_m[k];
    v = floor_div(sum + 64, 128);
    s = 1'b0;
    if (v > 127) begin v = 127; s = 1'b1; end
    else if (v < -128) begin v = -128; s = 1'b1; end
  endfunction

  function automatic void model_reset();
    hist.delete();
    expq.delete();
    satq.delete();
    coef_m = '{128, 0, 0, 0, 0, 0, 0, 0};
  endfunction

  task automatic chk(input string name, input int act, input int want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Stream monitor: sampled on the falling edge, mid-cycle.
  initial begin : monitor
    int e;
    bit s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (out_valid && out_ready) begin
          if (expq.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            e = expq.pop_front();
            s = satq.pop_front();
            chk("stream_data", int'(out_data), e);
            chk("stream_sat", int'(out_sat), int'(s));
          end
        end
        if (clear) begin
          hist.delete();
          expq.delete();
          satq.delete();
        end else if (in_valid && in_ready) begin
          hist.push_front(int'(in_data));
          if (hist.size() > 8) void'(hist.pop_back());
          model_eval(e, s);
          expq.push_back(e);
          satq.push_back(s);
        end
        if (coef_we) coef_m[coef_addr] = int'(coef_wdata);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we    = 1'b1;
    coef_addr  = 3'(a);
    coef_wdata = 8'(v);
    step();
    coef_we = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  typedef struct {
    bit byp;
    int c0;
    int c1;
    int xp;
    int xc;
    int exp_d;
    bit exp_s;
  } vec_t;

  vec_t tbl[8];

  initial begin : main
    tbl[0] = '{0, 127, 127, 127, 127, 127, 1};
    tbl[1] = '{0, 127, 127, -128, -128, -128, 1};
    tbl[2] = '{0, 64, 64, 10, 20, 15, 0};
    tbl[3] = '{1, 16, 0, 5, -100, -100, 0};
    tbl[4] = '{0, -128, 0, 100, -128, 127, 1};
    tbl[5] = '{0, -128, 0, 0, 1, -1, 0};
    tbl[6] = '{0, 0, 127, 100, 0, 99, 0};
    tbl[7] = '{0, 1, 1, -1, -1, 0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", int'(in_ready), 1);

    // Identity coefficients, back-to-back samples
    in_valid = 1'b1; in_data = 64;
    step();
    chk("id_no_early_valid", int'(out_valid), 0);
    in_data = -100;
    step();
    chk("id_valid0", int'(out_valid), 1);
    chk("id_data0", int'(out_data), 64);
    in_data = 127;
    step();
    chk("id_data1", int'(out_data), -100);
    in_valid = 1'b0;
    step();
    chk("id_data2", int'(out_data), 127);
    chk("id_sat2", int'(out_sat), 0);
    step();
    chk("id_valid_drop", int'(out_valid), 0);

    // Table vectors: two-tap patterns on a flushed line
    for (int i = 0; i < 8; i++) begin
      bypass = tbl[i].byp;
      do_clear();
      for (int a = 0; a < 8; a++)
        write_coef(a, (a == 0) ? tbl[i].c0 : (a == 1) ? tbl[i].c1 : 0);
      in_valid = 1'b1; in_data = 8'(tbl[i].xp);
      step();
      in_data = 8'(tbl[i].xc);
      step();
      in_valid = 1'b0;
      step();
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("tbl%0d_data", i), int'(out_data), tbl[i].exp_d);
      chk($sformatf("tbl%0d_sat", i), int'(out_sat), int'(tbl[i].exp_s));
    end
    bypass = 1'b0;
    step();

    // Averaging coefficients: 64 fed eight times ramps 8,16,...,64
    for (int a = 0; a < 8; a++) write_coef(a, 16);
    do_clear();
    in_valid = 1'b1; in_data = 64;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k >= 2) chk($sformatf("avg_k%0d", k - 1), int'(out_data), 8 * (k - 1));
    end
    in_valid = 1'b0;
    step();
    chk("avg_k8", int'(out_data), 64);
    step();

    // Backpressure: 5-cycle stall with a pending input
    do_clear();
    in_valid = 1'b1; in_data = 64; out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_data", int'(out_data), 8);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    repeat (4) step();
    in_valid = 1'b0;
    repeat (3) step();

    // Clear mid-stream, coefficients survive
    do_clear();
    in_valid = 1'b1; in_data = 64;
    repeat (3) step();
    in_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_valid_drop", int'(out_valid), 0);
    in_valid = 1'b1; in_data = 64;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_valid", int'(out_valid), 1);
    chk("clr_data", int'(out_data), 8);
    step();

    // Bypass with non-identity coefficients
    bypass = 1'b1;
    in_valid = 1'b1; in_data = -100;
    step();
    in_valid = 1'b0;
    step();
    chk("byp_data", int'(out_data), -100);
    chk("byp_sat", int'(out_sat), 0);
    step();
    bypass = 1'b0;

    // Reset mid-stream, identity coefficients restored
    in_valid = 1'b1; in_data = 50;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", int'(in_ready), 1);
    in_valid = 1'b1; in_data = 64;
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_identity", int'(out_data), 64);
    step();

    // Randomized streaming against the reference model
    for (int blk = 0; blk < 15; blk++) begin
      in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
      repeat (4) step();
      bypass = ($urandom % 4) == 0;
      for (int a = 0; a < 8; a++) write_coef(a, int'($urandom_range(0, 255)));
      for (int c = 0; c < 100; c++) begin
        in_valid  = ($urandom % 4) != 0;
        in_data   = 8'($urandom);
        out_ready = ($urandom % 4) != 0;
        clear     = ($urandom % 50) == 0;
        step();
      end
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_stream.md
Name: fir_stream

Overview:
- Parametrised, streaming direct-form FIR filter with runtime-loadable coefficients, valid/ready handshaking on input and output, and round/saturate output scaling.
- Successor to the fixed 8-bit FIR: generalised in data width, coefficient width and tap count; adds backpressure, a bypass mode and a saturation indicator.
- Sits between the sample source and downstream DSP or sink logic in the same clock domain.

Parameters:
- DATA_W, 8: signed input sample width.
- COEF_W, 8: signed coefficient width.
- TAPS, 8: number of taps; must be ≥2.
- OUT_W, 8: signed output width.
- SHIFT, 7: fractional bits of the coefficients (right shift applied to the sum); 0 ≤ SHIFT < DATA_W+COEF_W.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of delay line and valid bits; coefficients kept.
- bypass  in  1  1 = out_data is the input sample passed through round/saturate path unchanged, same latency.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DATA_W  signed sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- out_data  out  OUT_W  signed filtered result.
- out_sat  out  1  qualified by out_valid; 1 if this result was clipped.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index; 0 = newest sample.
- coef_wdata  in  COEF_W  signed coefficient.

Behaviour:
- Reset (rst_n low, asynchronous): delay line cleared, v1=0, out_valid=0, out_data=0, out_sat=0; coef[0]=1<<SHIFT, all other coefficients 0 (identity filter). in_ready=1 one cycle after release.
- Pipeline advance: adv = !out_valid | out_ready. in_ready = adv, combinational.
- Accept: in_valid & in_ready. On accept, the delay line shifts: x[0] <= in_data, x[k] <= x[k-1]. Otherwise the line holds. Stage-1 valid v1 <= accept whenever adv=1.
- Stage 2, on adv=1:
  - out_valid <= v1.
  - If v1, out_data <= sat(round(acc)), where acc = sum over k of x[k]*coef[k].
  - In bypass mode, acc = x[0]<<SHIFT.
- Latency: a sample accepted at edge N produces out_valid=1 at edge N+1 when not stalled.
- Stall: when out_valid & !out_ready, out_data, out_sat, out_valid, v1 and the delay line all hold; in_ready=0.
- Arithmetic:
  - Products are DATA_W+COEF_W bits, signed.
  - Accumulator is DATA_W+COEF_W+$clog2(TAPS) bits, so it cannot overflow.
  - Rounding: add 1<<(SHIFT-1) when SHIFT>0, then arithmetic shift right by SHIFT.
  - Saturation: clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 on clip.
- Coefficient write: coef[coef_addr] <= coef_wdata at the edge. The new value applies to sums computed at later edges. Writes are legal during streaming, stall or clear. An out-of-range address is ignored.
- clear (synchronous): delay line <= 0, v1 <= 0, out_valid <= 0; no accept that cycle (in_ready forced 0 while clear=1). clear has priority over accept and adv.
- Reset mid-stream: everything returns to reset state immediately, including coefficients; an in-flight result is dropped.
- Simultaneous accept and output handshake: both occur; throughput is 1 sample per cycle.

Decomposition:
- Package fir_stream_pkg:
  - acc_width function.
  - round_sat function (acc, SHIFT, OUT_W → value, sat bit).
  - Mode constants.
- Sub-module fir_stream_mac: combinational TAPS-wide multiply and adder tree; the top level holds the delay line, coefficient registers, handshake and output register.
- Target size: about 200 lines total.

Test Plan:
- Reset, then identity coefficients: feed 64, -100, 127 back-to-back with out_ready=1 → out_data 64, -100, 127 one cycle after each accept; out_sat=0; out_valid=0 before the first result.
- Load all 8 coefficients = 16, then feed 64 eight times → outputs 8, 16, 24 … 64, i.e. 64·16·k>>7 for k = 1..8.
- Saturation: coef0=coef1=127, feed 127, 127 → second output 32322>>7 = 252, clipped to 127 with out_sat=1. With inputs -128, -128 → second output clipped to -128... wait, (-128·127·2+64)>>7 = -254, clipped to -128 with out_sat=1.
- Backpressure: hold out_ready=0 while out_valid=1 for 5 cycles with in_valid=1 → in_ready=0, out_data stable, no samples lost. Release → the output sequence matches the unstalled golden model exactly.
- Clear mid-stream after 3 samples (averaging coefficients) → out_valid drops next cycle. The next sample 64 yields 8 (history zeroed), and coefficients are unchanged.
- Bypass=1 with coefficients of 16, feed -100 → out_data=-100 one cycle later. Asserting rst_n=0 mid-stream → out_valid=0 immediately, and identity coefficients are restored.
